// File: rtl/rx_nrzi_unstuff.sv
// rx_nrzi_unstuff - receive-side NRZI decoder, SYNC stripper and bit unstuffer.
//
// Takes the raw line bit coming from the DP/DM reader and produces a clean
// LSB-first payload stream that starts at the PID. The stream carries
// packet framing strobes and error flags.
//
// Ports:
//   clk        system clock, one line bit per cycle
//   rst        asynchronous active-high reset
//   bstr       raw line level (dp sample)
//   bstr_ready bstr valid this cycle; dropping it mid-packet aborts the packet
//   done       one-cycle end-of-packet strobe
//   out_bit    decoded, unstuffed payload bit
//   out_valid  out_bit valid this cycle
//   pkt_start  pulse with the first payload bit
//   pkt_end    pulse the cycle after done for a packet that reached payload
//   err_sync   sticky SYNC mismatch / truncated SYNC
//   err_stuff  sticky stuffing violation (too many consecutive ones)
//   pkt_bits   payload bit count, valid with pkt_end
//
// Build option: define RX_BITCNT_EN to implement the pkt_bits counter;
// otherwise pkt_bits is tied to zero.
module rx_nrzi_unstuff #(
  parameter int EOP_BITS  = 2,
  parameter int SYNC_LEN  = 8,
  parameter int STUFF_RUN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bstr,
  input  logic       bstr_ready,
  input  logic       done,
  output logic       out_bit,
  output logic       out_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       err_sync,
  output logic       err_stuff,
  output logic [9:0] pkt_bits
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, DROP} state_t;

  localparam int FW = $clog2(EOP_BITS + 1);
  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam int RW = $clog2(STUFF_RUN + 1);
  localparam logic [FW-1:0] FULL      = FW'(EOP_BITS);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(STUFF_RUN);

  state_t state, state_next;
  logic                prev_line;
  logic [EOP_BITS-1:0] line_q;
  logic [FW-1:0]       fill;
  logic [SW-1:0]       sync_cnt, sync_cnt_next;
  logic [RW-1:0]       ones_run, ones_run_next;
  logic                started, started_next;
  logic                out_bit_next, out_valid_next, pkt_start_next, pkt_end_next;
  logic                err_sync_next, err_stuff_next;
  logic                clr_cnt;

  logic push, dec, pop_valid, pop_bit, abort;

  assign push      = bstr_ready & ~done;
  assign dec       = (bstr == prev_line);
  // The delay line holds back the last EOP_BITS samples so that the SE0
  // samples can be thrown away when done arrives without ever reaching
  // the decoder.
  assign pop_valid = push & (fill == FULL);
  assign pop_bit   = line_q[EOP_BITS-1];
  assign abort     = ~bstr_ready & ~done & (state != IDLE);

  // State register, line history and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prev_line <= 1'b1;
      line_q    <= '0;
      fill      <= '0;
      sync_cnt  <= '0;
      ones_run  <= '0;
      started   <= 1'b0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      pkt_start <= 1'b0;
      pkt_end   <= 1'b0;
      err_sync  <= 1'b0;
      err_stuff <= 1'b0;
    end else begin
      state     <= state_next;
      sync_cnt  <= sync_cnt_next;
      ones_run  <= ones_run_next;
      started   <= started_next;
      out_bit   <= out_bit_next;
      out_valid <= out_valid_next;
      pkt_start <= pkt_start_next;
      pkt_end   <= pkt_end_next;
      err_sync  <= err_sync_next;
      err_stuff <= err_stuff_next;
      if (done || abort) begin
        fill      <= '0;
        prev_line <= 1'b1;
      end else if (push) begin
        prev_line <= bstr;
        line_q    <= EOP_BITS'({line_q, dec});
        if (fill != FULL) fill <= fill + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (done || abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (push) state_next = SYNC;
        SYNC: if (pop_valid) begin
          if (pop_bit != (sync_cnt == SYNC_LAST)) state_next = DROP;
          else if (sync_cnt == SYNC_LAST)         state_next = DATA;
        end
        DATA: if (pop_valid && ones_run == RUN_MAX && pop_bit) state_next = DROP;
        default: state_next = state;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    out_bit_next   = out_bit;
    out_valid_next = 1'b0;
    pkt_start_next = 1'b0;
    pkt_end_next   = 1'b0;
    err_sync_next  = err_sync;
    err_stuff_next = err_stuff;
    sync_cnt_next  = sync_cnt;
    ones_run_next  = ones_run;
    started_next   = started;
    clr_cnt        = 1'b0;
    if (done) begin
      pkt_end_next = (state == DATA);
      if (state == SYNC) err_sync_next = 1'b1;
    end else if (!abort) begin
      case (state)
        IDLE: if (push) begin
          err_sync_next  = 1'b0;
          err_stuff_next = 1'b0;
          sync_cnt_next  = '0;
          ones_run_next  = '0;
          started_next   = 1'b0;
          clr_cnt        = 1'b1;
        end
        SYNC: if (pop_valid) begin
          if (pop_bit != (sync_cnt == SYNC_LAST)) begin
            err_sync_next = 1'b1;
          end else begin
            sync_cnt_next = sync_cnt + 1'b1;
            // The closing one of SYNC already counts toward the stuff run.
            if (sync_cnt == SYNC_LAST) ones_run_next = RW'(1);
          end
        end
        DATA: if (pop_valid) begin
          if (ones_run == RUN_MAX) begin
            if (pop_bit) err_stuff_next = 1'b1;
            else         ones_run_next  = '0;
          end else begin
            out_bit_next   = pop_bit;
            out_valid_next = 1'b1;
            pkt_start_next = ~started;
            started_next   = 1'b1;
            ones_run_next  = pop_bit ? ones_run + 1'b1 : '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RX_BITCNT_EN
  logic [9:0] bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     bit_cnt <= '0;
    else if (clr_cnt)                            bit_cnt <= '0;
    else if (out_valid_next && bit_cnt != 10'd1023) bit_cnt <= bit_cnt + 1'b1;
  end

  assign pkt_bits = bit_cnt;
`else
  assign pkt_bits = 10'd0;
`endif

endmodule

// File: tb/tb_rx_nrzi_unstuff.sv
module tb_rx_nrzi_unstuff;
  logic       clk = 1'b0;
  logic       rst, bstr, bstr_ready, done;
  logic       out_bit, out_valid, pkt_start, pkt_end, err_sync, err_stuff;
  logic [9:0] pkt_bits;

  int   total = 0;
  int   bad   = 0;
  bit   exp_q[$];
  bit   first_pending = 1'b0;
  bit   mon_e;
  int   m_run;
  bit   m_dead;
  int   m_cnt;
  logic lvl = 1'b1;

`ifdef RX_BITCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  rx_nrzi_unstuff dut (
    .clk(clk), .rst(rst), .bstr(bstr), .bstr_ready(bstr_ready), .done(done),
    .out_bit(out_bit), .out_valid(out_valid), .pkt_start(pkt_start), .pkt_end(pkt_end),
    .err_sync(err_sync), .err_stuff(err_stuff), .pkt_bits(pkt_bits)
  );

  // Scoreboard monitor: every emitted bit must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_extra: got out_valid=1 bit=%0b, required no output", out_bit);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_bit !== mon_e) begin
            bad++;
            $display("FAIL out_bit: got %0b, required %0b", out_bit, mon_e);
          end else begin
            $display("out bit %0b ok", out_bit);
          end
        end
        total++;
        if (pkt_start !== first_pending) begin
          bad++;
          $display("FAIL pkt_start: got %0b, required %0b", pkt_start, first_pending);
        end
        first_pending = 1'b0;
      end else if (pkt_start) begin
        total++;
        bad++;
        $display("FAIL pkt_start_stray: got 1 without out_valid, required 0");
      end
    end
  end

  task automatic cycle(input logic rdy, input logic b, input logic dn);
    bstr_ready = rdy; bstr = b; done = dn;
    @(posedge clk); #1;
  endtask

  task automatic send_dec(input bit d);
    logic line;
    line = d ? lvl : ~lvl;
    lvl  = line;
    cycle(1'b1, line, 1'b0);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 8; i++) send_dec(i == 7);
  endtask

  task automatic model_start();
    m_run = 1; m_dead = 1'b0; m_cnt = 0; first_pending = 1'b1;
  endtask

  task automatic model_bit(input bit d);
    if (!m_dead) begin
      if (m_run == 6) begin
        if (d) m_dead = 1'b1;
        else   m_run  = 0;
      end else begin
        exp_q.push_back(d);
        m_cnt++;
        m_run = d ? m_run + 1 : 0;
      end
    end
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input int nmodel);
    for (int i = 0; i < n; i++) begin
      if (i < nmodel) model_bit(v[i]);
      send_dec(v[i]);
    end
  endtask

  // Two SE0 samples, then done; checks pkt_end timing and count.
  task automatic finish(input string name, input bit exp_end, input int nbits, input bit gap);
    logic [9:0] eb;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    lvl = 1'b1;
    total++;
    if (pkt_end !== exp_end) begin
      bad++;
      $display("FAIL %s pkt_end: got %0b, required %0b", name, pkt_end, exp_end);
    end
    if (exp_end) begin
      eb = CNT_EN ? 10'(nbits) : 10'd0;
      total++;
      if (pkt_bits !== eb) begin
        bad++;
        $display("FAIL %s pkt_bits: got %0d, required %0d", name, pkt_bits, eb);
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_out: got %0d pending bits, required 0", name, exp_q.size());
      exp_q.delete();
    end
    if (gap) begin
      cycle(1'b0, 1'b0, 1'b0);
      total++;
      if (pkt_end !== 1'b0) begin
        bad++;
        $display("FAIL %s pkt_end_width: got %0b, required 0", name, pkt_end);
      end
    end
    $display("%s packet finished, pkt_end=%0b pkt_bits=%0d", name, exp_end, pkt_bits);
  endtask

  task automatic check_flags(input string name, input bit es, input bit ef);
    total++;
    if ({err_sync, err_stuff} !== {es, ef}) begin
      bad++;
      $display("FAIL %s flags: got sync=%0b stuff=%0b, required sync=%0b stuff=%0b",
               name, err_sync, err_stuff, es, ef);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bstr = 1'b0; bstr_ready = 1'b0; done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_bit, out_valid, pkt_start, pkt_end, err_sync, err_stuff} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outs: got %06b, required 000000",
               {out_bit, out_valid, pkt_start, pkt_end, err_sync, err_stuff});
    end
    total++;
    if (pkt_bits !== 10'd0) begin
      bad++;
      $display("FAIL reset_pkt_bits: got %0d, required 0", pkt_bits);
    end
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    $display("reset checked");
  endtask

  task automatic test_a5();
    send_sync(); model_start();
    send_bits(16'h00A5, 8, 8);
    finish("a5", 1'b1, m_cnt, 1'b1);
    check_flags("a5", 1'b0, 1'b0);
  endtask

  task automatic test_stuff();
    send_sync(); model_start();
    send_bits(16'h005F, 8, 8);
    finish("stuff", 1'b1, m_cnt, 1'b1);
    check_flags("stuff", 1'b0, 1'b0);
  endtask

  task automatic test_stuff_err();
    send_sync(); model_start();
    send_bits(16'h017F, 9, 9);
    finish("stuff_err", 1'b0, 0, 1'b1);
    check_flags("stuff_err", 1'b0, 1'b1);
  endtask

  task automatic test_sync_err();
    logic [6:0] lines;
    lines = 7'b1011010;  // LSB first: 0,1,0,1,1,0,1
    model_start();
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, lines[i], 1'b0);
      if (i == 5) begin
        total++;
        if (err_sync !== 1'b0) begin
          bad++;
          $display("FAIL sync_err_early: got %0b, required 0", err_sync);
        end
        check_flags("sync_err_cleared", 1'b0, 1'b0);
      end
    end
    total++;
    if (err_sync !== 1'b1) begin
      bad++;
      $display("FAIL sync_err_set: got %0b, required 1", err_sync);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'(i & 1), 1'b0);
    finish("sync_err", 1'b0, 0, 1'b1);
    check_flags("sync_err", 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    logic       ob;
    logic [9:0] pb;
    send_sync(); model_start();
    send_bits(16'h0019, 6, 4);
    ob = out_bit; pb = pkt_bits;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b0 || out_bit !== ob || pkt_bits !== pb) begin
        bad++;
        $display("FAIL abort_gap: got valid=%0b bit=%0b bits=%0d, required valid=0 bit=%0b bits=%0d",
                 out_valid, out_bit, pkt_bits, ob, pb);
      end
    end
    check_flags("abort", 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    lvl = 1'b1;
    total++;
    if (pkt_end !== 1'b0) begin
      bad++;
      $display("FAIL abort_pkt_end: got %0b, required 0", pkt_end);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL abort_missing: got %0d pending bits, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("abort packet finished");
  endtask

  task automatic test_reset_mid();
    send_sync(); model_start();
    send_bits(16'h0007, 4, 2);
    rst = 1'b1;
    #1;
    total++;
    if ({out_bit, out_valid, pkt_start, pkt_end, err_sync, err_stuff} !== 6'b0 || pkt_bits !== 10'd0) begin
      bad++;
      $display("FAIL reset_mid: got %06b bits=%0d, required 000000 bits=0",
               {out_bit, out_valid, pkt_start, pkt_end, err_sync, err_stuff}, pkt_bits);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; lvl = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    send_sync(); model_start();
    send_bits(16'h003C, 8, 8);
    finish("after_reset", 1'b1, m_cnt, 1'b1);
    check_flags("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_sync(); model_start();
    send_bits(16'h0096, 8, 8);
    finish("b2b_first", 1'b1, m_cnt, 1'b0);
    send_sync(); model_start();
    send_bits(16'h00C3, 8, 8);
    finish("b2b_second", 1'b1, m_cnt, 1'b1);
    check_flags("b2b", 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_a5();
    test_stuff();
    test_stuff_err();
    test_sync_err();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_nrzi_unstuff.md
Name: rx_nrzi_unstuff

Overview:
- Receive-side stage directly downstream of the DP/DM reader.
- Consumes the raw per-cycle line bit (dp sample), its ready qualifier and the end-of-packet strobe.
- Performs NRZI decoding, checks and strips the 8-bit SYNC field, removes stuffed bits, and discards the SE0 samples of the EOP.
- Emits a clean serial payload (PID onward, LSB first) with packet framing strobes and error flags to the downstream deserializer/PID checker.

Parameters:
- EOP_BITS, 2, number of trailing line samples (SE0 period) discarded at end of packet; delay-line depth.
- SYNC_LEN, 8, number of decoded bits forming SYNC; expected pattern is SYNC_LEN-1 zeros followed by a one.
- STUFF_RUN, 6, count of consecutive decoded ones after which the next bit is a stuffed zero.

Ports:
- clk  input  1  system clock, one line bit per cycle.
- rst  input  1  reset; asynchronous, active-high.
- bstr  input  1  raw line bit (dp level) from DP/DM reader.
- bstr_ready  input  1  bstr valid this cycle (packet in progress).
- done  input  1  one-cycle EOP-complete strobe from DP/DM reader.
- out_bit  output  1  decoded, unstuffed payload bit.
- out_valid  output  1  out_bit valid this cycle.
- pkt_start  output  1  one-cycle pulse coincident with first payload bit.
- pkt_end  output  1  one-cycle pulse after last payload bit of a packet.
- err_sync  output  1  sticky until next packet: SYNC mismatch.
- err_stuff  output  1  sticky until next packet: STUFF_RUN+1 consecutive ones.
- pkt_bits  output  10  payload bit count, valid with pkt_end (see optional feature).

Behaviour:
- Reset: all outputs 0; state IDLE; prev_line=1 (J); delay line empty; counters 0.
- Push rule: a cycle with bstr_ready=1 and done=0 pushes one sample. The decoded bit is 1 if bstr==prev_line, else 0; prev_line<=bstr. Cycles with bstr_ready=0 push nothing (stall).
- Delay line: EOP_BITS entries. A push into a full line pops the oldest entry to the processor. Outputs are registered, so latency is EOP_BITS+1 cycles from push to out_bit.
- done=1: no push; delay-line contents are discarded. Next cycle: pkt_end=1 only if the state was DATA, and pkt_bits holds the count. State returns to IDLE, prev_line=1, delay line cleared.
- States:
  - IDLE: first push moves to SYNC and clears err_sync, err_stuff and the counters.
  - SYNC: counts popped bits 0..SYNC_LEN-1 and compares each to the expected pattern. On any mismatch: err_sync=1 and go to DROP. On the final match: go to DATA with ones_run=1 (the SYNC ending one counts toward the stuff run).
  - DATA: each popped bit is handled as follows.
    - ones_run==STUFF_RUN and bit=0: drop the bit, ones_run=0.
    - ones_run==STUFF_RUN and bit=1: err_stuff=1, go to DROP.
    - Otherwise: out_bit=bit, out_valid=1, pkt_bits+=1. ones_run increments on 1 (saturating at STUFF_RUN) and clears on 0. pkt_start accompanies the first emitted bit.
  - DROP: ignore pops until done, then return to IDLE. No pkt_end is issued (errors were already flagged).
- bstr_ready falling without done: treated as abort. Go to IDLE next cycle, no pkt_end, flags hold.
- done while in IDLE or SYNC: no pkt_end. If in SYNC, err_sync=1 (truncated).
- pkt_bits saturates at 1023.
- rst mid-packet: immediate return to the reset values above. The next packet needs fresh SYNC.

Optional Feature:
- RX_BITCNT_EN:
  - Defined: pkt_bits counter implemented as described.
  - Undefined: counter omitted and pkt_bits tied to 0; all other behaviour identical.

Test Plan:
- Line 0,1,0,1,0,1,0,0 (SYNC) followed by NRZI of payload 0xA5 LSB-first, then 2 SE0 samples (0,0), then done -> 8 out_valid bits 1,0,1,0,0,1,0,1; pkt_start with first bit; pkt_end one cycle after done; pkt_bits=8; no error flags.
- SYNC then payload bits 1,1,1,1,1,0,1,0 (decoded, with SYNC's trailing one) -> stuffed 0 after the 6th one dropped; emitted bits exclude it; ones_run reset.
- SYNC then 7 consecutive decoded ones in payload -> err_stuff=1; out_valid stays 0 afterwards; no pkt_end at done.
- Corrupt SYNC (line 0,1,0,1,1,...) -> err_sync=1 on the 5th popped bit; no out_valid for whole packet.
- bstr_ready held low for 3 cycles mid-payload -> treated as abort: state to IDLE next cycle, no pkt_end, flags hold; bench additionally checks that no out_bit or pkt_bits change occurs during the gap.
- Assert rst during DATA -> all outputs 0 that cycle. A following clean packet decodes correctly with prev_line restarting at 1.
